uart_xmit_engine: RTL and testbench

- Serial transmit stage directly downstream of the transmit FIFO, in the `clk` (FIFO read-clock) domain.
- Watches the FIFO `empty` flag and issues a one-cycle `load` request, which the FIFO edge-detects into its `rd_en`.
- Captures the byte the FIFO presents and shifts it out as 8N1 (or 8N2) UART frames on `tx`, reporting `busy` and `tx_done` back to the control logic.

---
 rtl/uart_xmit_engine.sv | 152 +++++++++++++++
 tb/tb_uart_xmit_engine.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_xmit_engine.sv
// UART transmit stage: pulls one byte from the upstream FIFO with a load pulse,
// then shifts it out LSB first as 8N1/8N2 with registered outputs.
//
// state     | meaning
// IDLE      | line high, waiting for tx_en=1 and a non-empty FIFO
// LOAD      | single-cycle read request to the FIFO
// WAIT_DATA | absorbing FIFO read latency, din captured on the last edge
// START     | start bit (line low)
// DATA      | eight data bits, LSB first
// STOP      | stop bit(s), tx_done in the final cycle
module uart_xmit_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 2,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] din,
  output logic       load,
  output logic       busy,
  output logic       tx_done,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_DATA, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(CLKS_PER_BIT - 2);
  localparam logic [7:0]  WAIT_LAST = 8'(RD_LAT - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  state_t      state, state_nxt;
  logic [15:0] baud_cnt, baud_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic        stop_idx, stop_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        load_nxt, busy_nxt, tx_done_nxt, tx_nxt;
  logic        baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      wait_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      load     <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      wait_cnt <= wait_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      shift    <= shift_nxt;
      load     <= load_nxt;
      busy     <= busy_nxt;
      tx_done  <= tx_done_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    wait_nxt    = wait_cnt;
    bit_nxt     = bit_idx;
    stop_nxt    = stop_idx;
    shift_nxt   = shift;
    load_nxt    = load;
    busy_nxt    = busy;
    tx_done_nxt = 1'b0;
    tx_nxt      = tx;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (tx_en && !empty) begin
          state_nxt = LOAD;
          load_nxt  = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      LOAD: begin
        load_nxt  = 1'b0;
        wait_nxt  = '0;
        state_nxt = WAIT_DATA;
      end
      WAIT_DATA: begin
        // read already committed, so empty/tx_en are deliberately ignored
        if (wait_cnt == WAIT_LAST) begin
          shift_nxt = din;
          tx_nxt    = 1'b0;
          baud_nxt  = '0;
          state_nxt = START;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            stop_nxt  = 1'b0;
            state_nxt = STOP;
          end else begin
            shift_nxt = {1'b0, shift[7:1]};
            tx_nxt    = shift[1];
            bit_nxt   = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (stop_idx == STOP_LAST) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            stop_nxt = stop_idx + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
          // registered pulse: raise one edge early so it lands in the last cycle
          if (baud_cnt == BAUD_PRE && stop_idx == STOP_LAST) tx_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_xmit_engine.sv
// Bench for uart_xmit_engine: FIFO model plus line monitor, expected bytes queued
// at stimulus time and compared against decoded frames.
module tb_uart_xmit_engine;

  localparam int C1 = 4;
  localparam int FRAME1 = 10 * C1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx_en = 1'b0;
  logic empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic load, busy, tx_done, tx;

  logic tx_en2 = 1'b1;
  logic empty2 = 1'b1;
  logic [7:0] din2 = 8'hFF;
  logic load2, busy2, tx_done2, tx2;

  uart_xmit_engine #(.CLKS_PER_BIT(C1), .RD_LAT(2), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .empty(empty), .din(din),
    .load(load), .busy(busy), .tx_done(tx_done), .tx(tx));

  uart_xmit_engine #(.CLKS_PER_BIT(2), .RD_LAT(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_en(tx_en2), .empty(empty2), .din(din2),
    .load(load2), .busy(busy2), .tx_done(tx_done2), .tx(tx2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: rd_en is the registered rising edge of load, data appears one edge later
  logic [7:0] fifo_q[$];
  logic load_d = 1'b0;
  logic rd_en = 1'b0;
  always @(posedge clk) begin
    load_d <= load;
    rd_en  <= load & ~load_d;
    if (rd_en && fifo_q.size() > 0) din <= fifo_q.pop_front();
    empty <= (fifo_q.size() == 0);
  end

  int load_cnt = 0, load_hi_cnt = 0, load_cyc = 0;
  int busy_rise = 0, busy_fall = 0, done_cnt = 0, done_cyc = 0;
  int load2_cnt = 0, done2_cnt = 0, done2_cyc = 0, busy2_fall = 0;
  logic load_prev = 1'b0, busy_prev = 1'b0, busy2_prev = 1'b0, load2_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (load) load_hi_cnt++;
    if (load && !load_prev) begin load_cnt++; load_cyc = cyc; end
    if (busy && !busy_prev) busy_rise = cyc;
    if (!busy && busy_prev) busy_fall = cyc;
    if (tx_done) begin done_cnt++; done_cyc = cyc; end
    if (load2 && !load2_prev) load2_cnt++;
    if (tx_done2) begin done2_cnt++; done2_cyc = cyc; end
    if (!busy2 && busy2_prev) busy2_fall = cyc;
    load_prev = load; busy_prev = busy; load2_prev = load2; busy2_prev = busy2;
  end

  // line monitor: every cycle of a frame captured, frames cut by reset discarded
  logic [FRAME1-1:0] got_line_q[$];
  int got_start_q[$];
  initial begin
    logic prev_tx;
    logic aborted;
    logic [FRAME1-1:0] buffer;
    int sc;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && prev_tx && !tx) begin
        sc = cyc; aborted = 1'b0; buffer = '0;
        buffer[0] = tx;
        for (int k = 1; k < FRAME1; k++) begin
          @(negedge clk);
          if (!rst) begin aborted = 1'b1; break; end
          buffer[k] = tx;
        end
        if (!aborted) begin got_line_q.push_back(buffer); got_start_q.push_back(sc); end
      end
      prev_tx = tx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [FRAME1-1:0] exp_line(input logic [7:0] b);
    logic [FRAME1-1:0] l;
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      l[C1*i +: C1] = {C1{v}};
    end
    return l;
  endfunction

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && got_line_q.size() < n; i++) @(negedge clk);
    check("frame_count", 64'(got_line_q.size()), 64'(n));
  endtask

  task automatic wait_load(input int base, input int budget);
    for (int i = 0; i < budget && load_cnt == base; i++) @(negedge clk);
    check("load_seen", 64'(load_cnt - base), 64'd1);
  endtask

  task automatic check_frame(input string tag, output int st);
    logic [FRAME1-1:0] ln;
    logic [7:0] eb;
    st = -1;
    if (got_line_q.size() > 0 && exp_q.size() > 0) begin
      ln = got_line_q.pop_front();
      st = got_start_q.pop_front();
      eb = exp_q.pop_front();
      check(tag, 64'(ln), 64'(exp_line(eb)));
    end else begin
      check({tag, "_missing"}, 64'(got_line_q.size()), 64'd1);
    end
  endtask

  initial begin
    int base, dbase, s1, s2, e0, sb;
    logic [21:0] line2;

    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({tx, load, busy, tx_done}), 64'(4'b1000));
    check("rst_outputs2", 64'({tx2, load2, busy2, tx_done2}), 64'(4'b1000));
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_hold", 64'({tx, load, busy, tx_done}), 64'(4'b1000));
    end

    // single byte 0xA5
    base = load_cnt; dbase = done_cnt;
    tx_en = 1'b1;
    fifo_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    wait_frames(1, 200);
    check_frame("frame_a5", s1);
    repeat (5) @(negedge clk);
    check("a5_load_pulses", 64'(load_cnt - base), 64'd1);
    check("a5_load_width", 64'(load_hi_cnt), 64'(load_cnt));
    check("a5_start_lat", 64'(s1 - load_cyc), 64'd3);
    check("a5_done_cnt", 64'(done_cnt - dbase), 64'd1);
    check("a5_done_pos", 64'(done_cyc + 1 - s1), 64'(FRAME1));
    check("a5_busy_rise", 64'(busy_rise), 64'(load_cyc));
    check("a5_busy_fall", 64'(busy_fall - s1), 64'(FRAME1));

    // back-to-back 0x55, 0x0F
    base = load_cnt;
    fifo_q.push_back(8'h55); fifo_q.push_back(8'h0F);
    exp_q.push_back(8'h55); exp_q.push_back(8'h0F);
    wait_frames(2, 300);
    check_frame("frame_55", s1);
    check_frame("frame_0f", s2);
    check("b2b_spacing", 64'(s2 - s1), 64'(FRAME1 + 1 + 2 + 1));
    repeat (60) @(negedge clk);
    check("b2b_load_pulses", 64'(load_cnt - base), 64'd2);
    check("b2b_empty", 64'(empty), 64'd1);
    check("b2b_load_width", 64'(load_hi_cnt), 64'(load_cnt));

    // empty throughout, then tx_en=0 with data present
    base = load_cnt;
    repeat (50) @(negedge clk);
    check("empty_no_load", 64'(load_cnt - base), 64'd0);
    check("empty_tx_idle", 64'(tx), 64'd1);
    tx_en = 1'b0;
    fifo_q.push_back(8'h3C); exp_q.push_back(8'h3C);
    repeat (50) @(negedge clk);
    check("dis_no_load", 64'(load_cnt - base), 64'd0);
    check("dis_tx_idle", 64'(tx), 64'd1);
    tx_en = 1'b1;
    wait_load(base, 20);
    fifo_q.push_back(8'h99);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    wait_frames(1, 200);
    check_frame("frame_3c", s1);
    repeat (60) @(negedge clk);
    check("drop_no_more_load", 64'(load_cnt - base), 64'd1);
    check("drop_idle", 64'({busy, tx}), 64'(2'b01));
    check("drop_fifo_left", 64'(fifo_q.size()), 64'd1);
    tx_en = 1'b1; exp_q.push_back(8'h99);
    wait_frames(1, 200);
    check_frame("frame_99", s1);
    repeat (5) @(negedge clk);

    // reset during data bit 3 of 0xC3, then 0x81 follows
    base = load_cnt;
    fifo_q.push_back(8'hC3); fifo_q.push_back(8'h81);
    exp_q.push_back(8'h81);
    wait_load(base, 20);
    e0 = load_cyc;
    for (int i = 0; i < 100 && cyc != e0 + 3 + 4 * C1 + 1; i++) @(negedge clk);
    check("pre_rst_bit3", 64'({busy, tx}), 64'(2'b10));
    #1 rst = 1'b0;
    #1 check("rst_async", 64'({tx, busy, load}), 64'(3'b100));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_frames(1, 200);
    check_frame("frame_81", s1);
    repeat (5) @(negedge clk);
    check("rst_no_extra", 64'(got_line_q.size()), 64'd0);

    // two stop bits, two clocks per bit, 0xFF
    base = load2_cnt; dbase = done2_cnt;
    empty2 = 1'b0;
    for (int i = 0; i < 20 && load2_cnt == base; i++) @(negedge clk);
    empty2 = 1'b1;
    check("s2_load", 64'(load2_cnt - base), 64'd1);
    for (int i = 0; i < 20 && tx2 != 1'b0; i++) @(negedge clk);
    sb = cyc;
    line2 = '0;
    line2[0] = tx2;
    for (int k = 1; k < 22; k++) begin
      @(negedge clk);
      line2[k] = tx2;
    end
    repeat (4) @(negedge clk);
    check("s2_line", 64'(line2), 64'(22'h3FFFFC));
    check("s2_done_cnt", 64'(done2_cnt - dbase), 64'd1);
    check("s2_done_pos", 64'(done2_cyc - sb), 64'd21);
    check("s2_busy_fall", 64'(busy2_fall - sb), 64'd22);
    check("s2_tx_idle", 64'({tx2, busy2}), 64'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
